serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer. It accepts a WIDTH-bit operation request and steps one external 1-bit ALU slice over the operands, LSB first, one bit per clock. It chains the carry between bits through a register, assembles the result, and reports N/Z/C/V flags with a done pulse. It lets a single slice replace a WIDTH-wide ALU array in area-constrained builds of the datapath.

---
 rtl/serial_alu_ctrl.sv | 119 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: steps an external 1-bit ALU slice over WIDTH-bit
// operands LSB first, chaining carry through a register, then reports N/Z/C/V.
module serial_alu_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carryOut,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_control,
    input  logic             slice_result,
    input  logic             slice_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       op;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_final;
    logic             arith;
    logic             illegal;
    logic             cin_msb;

    assign ready = (state == IDLE);

    // Slice drive is gated so the external slice sees all-zero outside RUN.
    assign slice_a       = (state == RUN) & a_sh[0];
    assign slice_b       = (state == RUN) & b_sh[0];
    assign slice_cin     = (state == RUN) & carry;
    assign slice_control = (state == RUN) ? op : 3'b000;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        res_next  = {slice_result, res_sh[WIDTH-1:1]};
        arith     = (op == 3'b010) || (op == 3'b011);
        illegal   = (op == 3'b001) || (op == 3'b111);
        res_final = illegal ? '0 : res_next;
        // Carry into the MSB is the carry register during the last bit cycle.
        cin_msb   = slice_cin;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
            zero     <= 1'b0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op       <= 3'b000;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        op     <= control;
                        cnt    <= '0;
                        // Subtraction is A + ~B + 1: the slice inverts B, we supply the +1.
                        carry  <= (control == 3'b011);
                        res_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= slice_cout;
                    if (cnt == LAST_BIT) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= res_final;
                        negative <= res_final[WIDTH-1];
                        zero     <= (res_final == '0);
                        carryOut <= arith & slice_cout;
                        overflow <= arith & (cin_msb ^ slice_cout);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl at WIDTH=8 and WIDTH=64, each DUT
// paired with a behavioural 1-bit slice and checked against an arithmetic model.
module tb_serial_alu_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start8, ready8, done8, n8, z8, c8, v8, sa8, sb8, sc8, sr8, sco8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  ctl8, sctl8;

    logic        start64, ready64, done64, n64, z64, c64, v64, sa64, sb64, sc64, sr64, sco64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  ctl64, sctl64;

    logic [63:0] prev8, prev64;

    serial_alu_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .control(ctl8),
        .ready(ready8), .done(done8), .result(res8),
        .negative(n8), .zero(z8), .carryOut(c8), .overflow(v8),
        .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_control(sctl8),
        .slice_result(sr8), .slice_cout(sco8)
    );

    serial_alu_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64), .control(ctl64),
        .ready(ready64), .done(done64), .result(res64),
        .negative(n64), .zero(z64), .carryOut(c64), .overflow(v64),
        .slice_a(sa64), .slice_b(sb64), .slice_cin(sc64), .slice_control(sctl64),
        .slice_result(sr64), .slice_cout(sco64)
    );

    // Behavioural 1-bit slice: returns {cout, result}.
    function automatic logic [1:0] slice_fn(input logic [2:0] c, input logic x, y, ci);
        logic [1:0] s;
        s = 2'b00;
        case (c)
            3'b000: s = {1'b0, y};
            3'b010: s = {1'b0, x} + {1'b0, y} + {1'b0, ci};
            3'b011: s = {1'b0, x} + {1'b0, ~y} + {1'b0, ci};
            3'b100: s = {1'b0, x & y};
            3'b101: s = {1'b0, x | y};
            3'b110: s = {1'b0, x ^ y};
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    always_comb {sco8, sr8}   = slice_fn(sctl8, sa8, sb8, sc8);
    always_comb {sco64, sr64} = slice_fn(sctl64, sa64, sb64, sc64);

    // Whole-word reference: plain arithmetic with signed-overflow rule on operand signs.
    function automatic void model(input int w, input logic [2:0] op, input logic [63:0] av, bv,
                                  output logic [63:0] r, output logic [3:0] nzcv);
        logic [64:0] mask, s;
        logic        sa, sb, n, z, c, v;
        mask = (65'd1 << w) - 65'd1;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: r = bv & mask[63:0];
            3'b010: s = ({1'b0, av} & mask) + ({1'b0, bv} & mask);
            3'b011: s = ({1'b0, av} & mask) + ((~{1'b0, bv}) & mask) + 65'd1;
            3'b100: r = av & bv & mask[63:0];
            3'b101: r = (av | bv) & mask[63:0];
            3'b110: r = (av ^ bv) & mask[63:0];
            default: r = '0;
        endcase
        if (op == 3'b010 || op == 3'b011) begin
            r  = s[63:0] & mask[63:0];
            c  = s[w];
            sa = av[w-1];
            sb = (op == 3'b011) ? ~bv[w-1] : bv[w-1];
            v  = (sa == sb) && (r[w-1] != sa);
        end
        n = r[w-1];
        z = (r == '0);
        nzcv = {n, z, c, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 8) ? ready8 : ready64;
    endfunction
    function automatic logic dn(input int w);
        return (w == 8) ? done8 : done64;
    endfunction
    function automatic logic [63:0] res(input int w);
        return (w == 8) ? {56'b0, res8} : res64;
    endfunction
    function automatic logic [3:0] flg(input int w);
        return (w == 8) ? {n8, z8, c8, v8} : {n64, z64, c64, v64};
    endfunction
    function automatic logic [5:0] slc(input int w);
        return (w == 8) ? {sa8, sb8, sc8, sctl8} : {sa64, sb64, sc64, sctl64};
    endfunction

    task automatic drive(input int w, input logic s, input logic [2:0] op, input logic [63:0] av, bv);
        if (w == 8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; ctl8 = op;
        end else begin
            start64 = s; a64 = av; b64 = bv; ctl64 = op;
        end
    endtask

    // One operation: accept, optionally poke start mid-RUN, then check latency, result and flags.
    task automatic do_op(input int w, input logic [2:0] op, input logic [63:0] av, bv, input bit pulse);
        logic [63:0] er;
        logic [3:0]  ef;
        int          k;
        model(w, op, av, bv, er, ef);
        @(negedge clk);
        check("ready_idle", rdy(w), 1'b1);
        drive(w, 1'b1, op, av, bv);
        @(negedge clk);
        drive(w, 1'b0, op, av, bv);
        k = 1;
        check("ready_run", rdy(w), 1'b0);
        check("hold_result", res(w), (w == 8) ? prev8 : prev64);
        check("slice_ctl", slc(w) & 6'h07, op);
        check("slice_cin0", slc(w) >> 3 & 6'h01, op == 3'b011);
        while (!dn(w) && k < w + 8) begin
            if (pulse && k == 3) drive(w, 1'b1, 3'b110, ~av, ~bv);
            else                 drive(w, 1'b0, op, av, bv);
            @(negedge clk);
            k++;
        end
        check("done_latency", k, w + 1);
        check("result", res(w), er);
        check("flags_nzcv", flg(w), ef);
        if (w == 8) prev8 = er; else prev64 = er;
        @(negedge clk);
        check("done_pulse", dn(w), 1'b0);
        check("ready_back", rdy(w), 1'b1);
        @(negedge clk);
        check("no_queue", rdy(w), 1'b1);
    endtask

    logic [2:0] ops [8] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b111};

    initial begin
        logic [63:0] er, av, bv;
        logic [3:0]  ef;
        int          times [3];
        int          nd;
        bit          seen;
        int          w;

        reset = 1'b0;
        drive(8, 1'b0, 3'b000, '0, '0);
        drive(64, 1'b0, 3'b000, '0, '0);
        prev8 = '0;
        prev64 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready8", ready8, 1'b1);
        check("rst_done8", done8, 1'b0);
        check("rst_result8", res8, 8'h00);
        check("rst_flags8", flg(8), 4'h0);
        check("rst_slice8", slc(8), 6'h00);
        check("rst_ready64", ready64, 1'b1);
        check("rst_result64", res64, 64'h0);
        check("rst_slice64", slc(64), 6'h00);
        reset = 1'b1;

        do_op(8, 3'b010, 64'h7F, 64'h01, 1'b0);
        check("add_7f_flags", flg(8), 4'b1001);
        do_op(8, 3'b011, 64'h05, 64'h05, 1'b0);
        check("sub_eq_flags", flg(8), 4'b0110);
        do_op(8, 3'b011, 64'h00, 64'h01, 1'b0);
        check("sub_borrow_res", res8, 8'hFF);
        do_op(8, 3'b100, 64'hF0, 64'h3C, 1'b0);
        check("and_res", res8, 8'h30);
        do_op(8, 3'b101, 64'hF0, 64'h3C, 1'b0);
        check("or_res", res8, 8'hFC);
        do_op(8, 3'b110, 64'hF0, 64'h3C, 1'b0);
        check("xor_res", res8, 8'hCC);
        do_op(8, 3'b111, 64'hA5, 64'h5A, 1'b0);
        check("illegal_zero", z8, 1'b1);
        do_op(8, 3'b010, 64'h21, 64'h13, 1'b1);
        check("pulse_ignored_res", res8, 8'h34);
        do_op(8, 3'b000, 64'hF0, 64'h3C, 1'b0);
        check("pass_b_res", res8, 8'h3C);

        // Abort mid-RUN with a nonzero visible result outstanding.
        @(negedge clk);
        drive(8, 1'b1, 3'b010, 64'h12, 64'h34);
        @(negedge clk);
        drive(8, 1'b0, 3'b010, 64'h12, 64'h34);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_ready", ready8, 1'b1);
        check("abort_done", done8, 1'b0);
        check("abort_result", res8, 8'h00);
        check("abort_flags", flg(8), 4'h0);
        check("abort_slice", slc(8), 6'h00);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        prev8 = '0;
        prev64 = '0;

        do_op(64, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check("add64_wrap_flags", flg(64), 4'b0110);

        // start held high: back-to-back acceptances every WIDTH+2 cycles.
        av = 64'($urandom_range(0, 255));
        bv = 64'($urandom_range(0, 255));
        model(8, 3'b010, av, bv, er, ef);
        @(negedge clk);
        drive(8, 1'b1, 3'b010, av, bv);
        nd = 0;
        for (int t = 1; t <= 40 && nd < 3; t++) begin
            @(negedge clk);
            if (done8) begin
                times[nd] = t;
                nd++;
                check("hold_start_res", res8, er[7:0]);
            end
        end
        drive(8, 1'b0, 3'b010, av, bv);
        check("hold_start_count", nd, 3);
        if (nd == 3) begin
            check("hold_first_done", times[0], 9);
            check("hold_period1", times[1] - times[0], 10);
            check("hold_period2", times[2] - times[1], 10);
        end
        prev8 = er;
        @(negedge clk);
        check("hold_release_ready", ready8, 1'b1);

        for (int i = 0; i < 30; i++) begin
            w  = (i % 4 == 3) ? 64 : 8;
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if (i % 5 == 0) bv = av;
            if (w == 8) begin
                av = av & 64'hFF;
                bv = bv & 64'hFF;
            end
            do_op(w, ops[$urandom_range(0, 7)], av, bv, bit'(i % 7 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
